// File: rtl/panel_input.sv
// Front-panel input conditioner: sync, debounce and a select/run FSM
// producing on / mode / m_pos / cancel for the wash controller.
module panel_input #(
  parameter int DB_CYCLES   = 2000000,
  parameter int LONG_CYCLES = 200000000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_power,
  input  logic       btn_start,
  input  logic       btn_mode,
  output logic       on,
  output logic [1:0] mode,
  output logic       m_pos,
  output logic       cancel,
  output logic [3:0] mode_led
);

  typedef enum logic [1:0] {
    OFF,
    SELECT,
    RUN,
    WAIT_REL
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  // bit 0 power, bit 1 start, bit 2 mode
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       stab;
  logic [1:0]       btn_q;
  logic [CNT_W-1:0] db_cnt [3];
  logic [CNT_W-1:0] hold;
  logic             rise_start;
  logic             rise_mode;
  logic             hold_done;
  state_t           state;
  state_t           state_n;

  assign raw = {btn_mode, btn_start, sw_power};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      stab <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stab[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          stab[i]   <= ~stab[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) btn_q <= '0;
    else      btn_q <= stab[2:1];
  end

  assign on         = stab[0];
  assign rise_start = stab[1] & ~btn_q[0];
  assign rise_mode  = stab[2] & ~btn_q[1];
  assign hold_done  = (state == RUN) & on & stab[1] & (hold == LONG_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold   <= '0;
      cancel <= 1'b0;
      mode   <= 2'b11;
    end else begin
      cancel <= hold_done;
      if (hold_done)
        hold <= '0;
      else if (state == RUN && on && stab[1])
        hold <= hold + 1'b1;
      else
        hold <= '0;
      // start beats mode when both rise together
      if (state == SELECT && on && rise_mode && !rise_start)
        mode <= mode + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= OFF;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!on) begin
      state_n = OFF;
    end else begin
      unique case (state)
        OFF:      state_n = SELECT;
        SELECT:   if (rise_start) state_n = RUN;
        RUN:      if (hold_done) state_n = WAIT_REL;
        WAIT_REL: if (!stab[1]) state_n = SELECT;
        default:  state_n = OFF;
      endcase
    end
  end

  always_comb begin
    m_pos    = (state == RUN);
    mode_led = 4'b0001 << mode;
  end

endmodule

// File: tb/tb_panel_input.sv
// Randomised self-checking bench for panel_input against a
// cycle-level behavioural model of the panel rules.
module tb_panel_input;

  localparam int DB   = 4;
  localparam int LONG = 16;
  localparam int S_OFF  = 0;
  localparam int S_SEL  = 1;
  localparam int S_RUN  = 2;
  localparam int S_WAIT = 3;
  localparam logic [8:0] RST_V = 9'b0_11_0_0_1000;

  typedef struct {
    logic [2:0] pins;
    int         len;
  } seg_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_power = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_mode = 1'b0;
  logic       on;
  logic [1:0] mode;
  logic       m_pos;
  logic       cancel;
  logic [3:0] mode_led;

  int errors = 0;
  int checks = 0;

  panel_input #(
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LONG),
    .CNT_W      (28)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_power (sw_power),
    .btn_start(btn_start),
    .btn_mode (btn_mode),
    .on       (on),
    .mode     (mode),
    .m_pos    (m_pos),
    .cancel   (cancel),
    .mode_led (mode_led)
  );

  always #5 clk = ~clk;

  // model: pin pipeline, debounced levels as "last DB seen samples all
  // disagree with the level", and the panel rules as plain state steps
  logic [2:0]    p1 = '0;
  logic [2:0]    p2 = '0;
  logic [2:0]    m_st = '0;
  logic [2:0]    m_prv = '0;
  logic [DB-1:0] hist [3];
  int            hv [3];
  int            m_state = S_OFF;
  int            held = 0;
  logic [1:0]    m_mode = 2'b11;
  logic          m_cancel = 1'b0;

  always @(posedge clk) begin : model
    logic [2:0] pins;
    logic [2:0] seen;
    logic       rs;
    logic       rm;
    pins = {btn_mode, btn_start, sw_power};
    if (!rst) begin
      p1 = '0;
      p2 = '0;
      m_st = '0;
      m_prv = '0;
      for (int i = 0; i < 3; i++) begin
        hist[i] = '0;
        hv[i] = 0;
      end
      m_state = S_OFF;
      held = 0;
      m_mode = 2'b11;
      m_cancel = 1'b0;
    end else begin
      rs = m_st[1] & ~m_prv[1];
      rm = m_st[2] & ~m_prv[2];
      m_cancel = 1'b0;
      if (!m_st[0]) begin
        m_state = S_OFF;
        held = 0;
      end else begin
        case (m_state)
          S_OFF: m_state = S_SEL;
          S_SEL: begin
            if (rs) begin
              m_state = S_RUN;
              held = 0;
            end else if (rm) begin
              m_mode = m_mode + 2'd1;
            end
          end
          S_RUN: begin
            if (!m_st[1]) begin
              held = 0;
            end else begin
              held++;
              if (held == LONG) begin
                m_cancel = 1'b1;
                held = 0;
                m_state = S_WAIT;
              end
            end
          end
          default: if (!m_st[1]) m_state = S_SEL;
        endcase
      end
      m_prv = m_st;
      seen = p2;
      p2 = p1;
      p1 = pins;
      for (int i = 0; i < 3; i++) begin
        hist[i] = {hist[i][DB-2:0], seen[i]};
        if (hv[i] < DB) hv[i]++;
        if (hv[i] == DB && hist[i] == {DB{~m_st[i]}})
          m_st[i] = ~m_st[i];
      end
    end
  end

  function automatic logic [8:0] got_v();
    return {on, mode, m_pos, cancel, mode_led};
  endfunction

  function automatic logic [8:0] want_v();
    logic [3:0] led;
    led = 4'b0001 << m_mode;
    return {m_st[0], m_mode, m_state == S_RUN, m_cancel, led};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    {btn_mode, btn_start, sw_power} = 3'b000;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (got_v() !== RST_V) begin
        errors++;
        $display("FAIL reset_vals: got %b want %b", got_v(), RST_V);
      end
      checks++;
      if (got_v() !== want_v()) begin
        errors++;
        $display("FAIL reset_model: got %b want %b", got_v(), want_v());
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_power_on();
    int g;
    int first;
    g = int'($urandom_range(1, 3));
    first = 0;
    sw_power = 1'b1;
    repeat (g) begin
      @(negedge clk);
      checks++;
      if (on !== 1'b0 || got_v() !== want_v()) begin
        errors++;
        $display("FAIL glitch_on: got %b want %b", got_v(), want_v());
      end
    end
    sw_power = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (on !== 1'b0 || got_v() !== want_v()) begin
        errors++;
        $display("FAIL glitch_off: got %b want %b", got_v(), want_v());
      end
    end
    sw_power = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (on === 1'b1 && first == 0) first = c;
      checks++;
      if (got_v() !== want_v()) begin
        errors++;
        $display("FAIL power_model: got %b want %b", got_v(), want_v());
      end
    end
    checks++;
    if (first != 6) begin
      errors++;
      $display("FAIL power_latency: got %0d cycles want 6", first);
    end
  endtask

  task automatic test_mode_press();
    seg_t s[$];
    for (int k = 0; k < 3; k++) begin
      s.push_back('{3'b101, int'($urandom_range(6, 10))});
      s.push_back('{3'b001, int'($urandom_range(8, 12))});
    end
    foreach (s[k]) begin
      {btn_mode, btn_start, sw_power} = s[k].pins;
      repeat (s[k].len) begin
        @(negedge clk);
        checks++;
        if (got_v() !== want_v()) begin
          errors++;
          $display("FAIL mode_model: got %b want %b", got_v(), want_v());
        end
      end
    end
    checks++;
    if (mode !== 2'b10 || mode_led !== 4'b0100) begin
      errors++;
      $display("FAIL mode_three: got %b/%b want 10/0100", mode, mode_led);
    end
    s.delete();
    s.push_back('{3'b101, 1});
    s.push_back('{3'b001, 1});
    s.push_back('{3'b101, 9});
    s.push_back('{3'b001, 12});
    foreach (s[k]) begin
      {btn_mode, btn_start, sw_power} = s[k].pins;
      repeat (s[k].len) begin
        @(negedge clk);
        checks++;
        if (got_v() !== want_v()) begin
          errors++;
          $display("FAIL bounce_model: got %b want %b", got_v(), want_v());
        end
      end
    end
    checks++;
    if (mode !== 2'b11 || mode_led !== 4'b1000) begin
      errors++;
      $display("FAIL mode_bounce: got %b/%b want 11/1000", mode, mode_led);
    end
  endtask

  task automatic test_start_and_mode();
    seg_t s[$];
    s.push_back('{3'b111, 8});
    s.push_back('{3'b001, 12});
    foreach (s[k]) begin
      {btn_mode, btn_start, sw_power} = s[k].pins;
      repeat (s[k].len) begin
        @(negedge clk);
        checks++;
        if (got_v() !== want_v()) begin
          errors++;
          $display("FAIL same_model: got %b want %b", got_v(), want_v());
        end
      end
    end
    checks++;
    if (m_pos !== 1'b1 || mode !== 2'b11) begin
      errors++;
      $display("FAIL start_wins: got m_pos=%b mode=%b want 1/11", m_pos, mode);
    end
    s.delete();
    for (int k = 0; k < 2; k++) begin
      s.push_back('{3'b101, 8});
      s.push_back('{3'b001, 12});
    end
    foreach (s[k]) begin
      {btn_mode, btn_start, sw_power} = s[k].pins;
      repeat (s[k].len) begin
        @(negedge clk);
        checks++;
        if (got_v() !== want_v()) begin
          errors++;
          $display("FAIL run_mode_model: got %b want %b", got_v(), want_v());
        end
      end
    end
    checks++;
    if (m_pos !== 1'b1 || mode !== 2'b11) begin
      errors++;
      $display("FAIL mode_frozen: got m_pos=%b mode=%b want 1/11", m_pos, mode);
    end
  endtask

  task automatic test_long_cancel();
    seg_t s[$];
    int pulses;
    pulses = 0;
    s.push_back('{3'b011, 24});
    s.push_back('{3'b001, 30});
    foreach (s[k]) begin
      {btn_mode, btn_start, sw_power} = s[k].pins;
      repeat (s[k].len) begin
        @(negedge clk);
        if (cancel === 1'b1) pulses++;
        checks++;
        if (got_v() !== want_v() || (cancel === 1'b1 && m_pos !== 1'b0)) begin
          errors++;
          $display("FAIL cancel_model: got %b want %b", got_v(), want_v());
        end
      end
    end
    checks++;
    if (pulses != 1 || m_pos !== 1'b0) begin
      errors++;
      $display("FAIL cancel_once: got %0d pulses m_pos=%b want 1/0", pulses, m_pos);
    end
  endtask

  task automatic test_power_drop_and_reset();
    seg_t s[$];
    int pulses;
    pulses = 0;
    s.push_back('{3'b011, 8});
    s.push_back('{3'b001, 12});
    s.push_back('{3'b011, 4});
    s.push_back('{3'b010, 14});
    foreach (s[k]) begin
      {btn_mode, btn_start, sw_power} = s[k].pins;
      repeat (s[k].len) begin
        @(negedge clk);
        if (cancel === 1'b1) pulses++;
        checks++;
        if (got_v() !== want_v()) begin
          errors++;
          $display("FAIL drop_model: got %b want %b", got_v(), want_v());
        end
      end
    end
    checks++;
    if (pulses != 0 || on !== 1'b0 || m_pos !== 1'b0 || mode !== 2'b11) begin
      errors++;
      $display("FAIL power_drop: got cancels=%0d on=%b m_pos=%b mode=%b want 0/0/0/11",
               pulses, on, m_pos, mode);
    end
    s.delete();
    s.push_back('{3'b000, 10});
    s.push_back('{3'b001, 12});
    s.push_back('{3'b011, 8});
    s.push_back('{3'b001, 12});
    foreach (s[k]) begin
      {btn_mode, btn_start, sw_power} = s[k].pins;
      repeat (s[k].len) begin
        @(negedge clk);
        checks++;
        if (got_v() !== want_v()) begin
          errors++;
          $display("FAIL rerun_model: got %b want %b", got_v(), want_v());
        end
      end
    end
    checks++;
    if (m_pos !== 1'b1) begin
      errors++;
      $display("FAIL rerun: got m_pos=%b want 1", m_pos);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (got_v() !== RST_V) begin
      errors++;
      $display("FAIL mid_reset: got %b want %b", got_v(), RST_V);
    end
    rst = 1'b1;
  endtask

  task automatic test_random();
    int         rem [3];
    logic [2:0] pins;
    rem = '{0, 0, 0};
    pins = 3'b001;
    repeat (1500) begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0) begin
          if (i == 0) begin
            pins[i] = ($urandom_range(0, 7) != 0);
            rem[i] = int'($urandom_range(1, 60));
          end else begin
            pins[i] = 1'($urandom_range(0, 1));
            rem[i] = int'($urandom_range(1, 30));
          end
        end else begin
          rem[i]--;
        end
      end
      {btn_mode, btn_start, sw_power} = pins;
      @(negedge clk);
      checks++;
      if (got_v() !== want_v()) begin
        errors++;
        $display("FAIL random_model: got %b want %b", got_v(), want_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_mode_press();
    test_start_and_mode();
    test_long_cancel();
    test_power_drop_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
